// File: rtl/pid_sched.sv
// rtl/pid_sched.sv - sampled PID request scheduler with timeout fault and actuator update
// Optional feature macro SLEW_LIMIT_EN: rate-limit each actuator update to +/-SLEW.
module pid_sched #(
    parameter int          DIV     = 100,
    parameter int          TIMEOUT = 15,
    parameter logic [15:0] SP_WALK = 16'd1000,
    parameter logic [15:0] SP_TURN = 16'd500,
    parameter logic [15:0] SLEW    = 16'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic [15:0] y_feedback,
    output logic        pid_req,
    output logic [15:0] pid_err,
    input  logic        pid_ack,
    input  logic [15:0] pid_u,
    output logic        pid_clr,
    output logic [15:0] actuator_out,
    output logic        fault
);
    localparam int DW = $clog2(DIV + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_WALK = 2'd1;
    localparam logic [1:0] M_TURN = 2'd2;
    localparam logic [1:0] M_STOP = 2'd3;

`ifdef SLEW_LIMIT_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_WAIT, S_SAMPLE, S_REQ, S_APPLY} state_t;

    state_t        state_q;
    logic [DW-1:0] div_cnt_q;
    logic [TW-1:0] req_cnt_q;
    logic [1:0]    mode_q;
    logic [15:0]   target_q;
    logic          req_q;
    logic          clr_q;
    logic          fault_q;
    logic [15:0]   err_q;
    logic [15:0]   act_q;

    logic [15:0]        setpoint;
    logic signed [16:0] diff;
    logic [15:0]        err_d;
    logic [15:0]        tgt_clamped;
    logic [15:0]        act_d;

    // Sampling happens on the edge that enters SAMPLE, so err/clr are visible during SAMPLE.
    always_comb begin
        setpoint = 16'd0;
        if (mode == M_WALK) begin
            setpoint = SP_WALK;
        end else if (mode == M_TURN) begin
            setpoint = SP_TURN;
        end
        diff  = $signed({1'b0, setpoint}) - $signed({1'b0, y_feedback});
        err_d = (diff < -17'sd32768) ? 16'h8000 : diff[15:0];
    end

    always_comb begin
        tgt_clamped = target_q[15] ? 16'd0 : target_q;
        act_d       = tgt_clamped;
        if (SLEW_EN) begin
            if ({1'b0, tgt_clamped} > ({1'b0, act_q} + {1'b0, SLEW})) begin
                act_d = act_q + SLEW;
            end else if (({1'b0, tgt_clamped} + {1'b0, SLEW}) < {1'b0, act_q}) begin
                act_d = act_q - SLEW;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_WAIT;
            div_cnt_q <= '0;
            req_cnt_q <= '0;
            mode_q    <= M_IDLE;
            target_q  <= 16'd0;
            req_q     <= 1'b0;
            clr_q     <= 1'b0;
            fault_q   <= 1'b0;
            err_q     <= 16'd0;
            act_q     <= 16'd0;
        end else begin
            clr_q <= 1'b0;
            case (state_q)
                S_WAIT: begin
                    if (div_cnt_q == DW'(DIV - 1)) begin
                        state_q   <= S_SAMPLE;
                        div_cnt_q <= '0;
                        mode_q    <= mode;
                        err_q     <= err_d;
                        clr_q     <= (mode != mode_q);
                        if (mode == M_STOP) begin
                            fault_q <= 1'b0;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (mode_q == M_WALK || mode_q == M_TURN) begin
                        state_q   <= S_REQ;
                        req_q     <= 1'b1;
                        req_cnt_q <= '0;
                    end else begin
                        state_q  <= S_APPLY;
                        target_q <= 16'd0;
                    end
                end
                S_REQ: begin
                    // An ack on the final allowed cycle still wins over the timeout.
                    if (pid_ack) begin
                        target_q <= pid_u;
                        req_q    <= 1'b0;
                        state_q  <= S_APPLY;
                    end else if (req_cnt_q == TW'(TIMEOUT - 1)) begin
                        fault_q  <= 1'b1;
                        req_q    <= 1'b0;
                        target_q <= 16'd0;
                        state_q  <= S_APPLY;
                    end else begin
                        req_cnt_q <= req_cnt_q + 1'b1;
                    end
                end
                S_APPLY: begin
                    act_q     <= act_d;
                    state_q   <= S_WAIT;
                    div_cnt_q <= '0;
                end
                default: state_q <= S_WAIT;
            endcase
        end
    end

    assign pid_req      = req_q;
    assign pid_err      = err_q;
    assign pid_clr      = clr_q;
    assign actuator_out = act_q;
    assign fault        = fault_q;
endmodule

// File: doc/pid_sched.md
PID_SCHED -- requirements
Module: pid_sched

Interface
REQ-001 SHALL have parameter DIV, 100, WAIT-state cycles between samples (>=2).
REQ-002 SHALL have parameter TIMEOUT, 15, REQ-state cycles allowed before fault.
REQ-003 SHALL have parameter SP_WALK, 16'd1000, WALK setpoint (<=32767).
REQ-004 SHALL have parameter SP_TURN, 16'd500, TURN setpoint (<=32767).
REQ-005 SHALL have parameter SLEW, 16'd64, maximum actuator step per update.
REQ-006 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port mode  in  2  mode: 0 IDLE, 1 WALK, 2 TURN, 3 STOP.
REQ-009 SHALL have port y_feedback  in  16  measured plant output, unsigned.
REQ-010 SHALL have port pid_req  out  1  compute request to the PID datapath.
REQ-011 SHALL have port pid_err  out  16  signed error presented with pid_req.
REQ-012 SHALL have port pid_ack  in  1  PID result valid, one-cycle pulse.
REQ-013 SHALL have port pid_u  in  16  signed PID output, valid with pid_ack.
REQ-014 SHALL have port pid_clr  out  1  one-cycle integrator clear pulse.
REQ-015 SHALL have port actuator_out  out  16  registered actuator command, unsigned.
REQ-016 SHALL have port fault  out  1  sticky PID timeout flag.

Function
REQ-017 SHALL implement the states WAIT, SAMPLE, REQ and APPLY.
REQ-018 SHALL, in WAIT, count cycles from 0 on entry and go to SAMPLE after DIV cycles.
REQ-019 SHALL, in SAMPLE, latch mode and y_feedback, then compute pid_err = setpoint - y as a 17-bit signed value saturated to [-32768, 32767].
REQ-020 SHALL, in SAMPLE, pulse pid_clr for one cycle when the latched mode differs from the previously latched mode.
REQ-021 SHALL, when the latched mode is IDLE or STOP, skip REQ and go to APPLY with target 0.
REQ-022 SHALL, when the latched mode is STOP, clear fault in SAMPLE.
REQ-023 SHALL, when the latched mode is WALK or TURN, go to REQ.
REQ-024 SHALL, in REQ, hold pid_req=1 and pid_err stable until pid_ack is sampled high.
REQ-025 SHALL, on pid_ack, latch pid_u as target and go to APPLY on the next edge.
REQ-026 SHALL ignore pid_ack outside REQ.
REQ-027 SHALL, after TIMEOUT REQ cycles without pid_ack, set fault, drop pid_req, and go to APPLY with target 0.
REQ-028 SHALL, in APPLY, clamp a negative target to 0, update actuator_out, then return to WAIT.
REQ-029 SHALL update actuator_out only in APPLY, one edge after the edge that samples pid_ack.
REQ-030 SHALL not abort an outstanding request when mode changes in REQ; the new mode takes effect at the next SAMPLE.

Reset
REQ-031 SHALL, on rst low, immediately force state WAIT, the counters to 0, pid_req, pid_clr, fault and pid_err to 0, actuator_out to 0, and the previous mode to IDLE, including mid-REQ.
REQ-032 SHALL, after rst is released, begin counting in WAIT on the first rising edge.

Configuration
REQ-033 SHALL, with SLEW_LIMIT_EN defined, limit each APPLY change of actuator_out to +/-SLEW toward the clamped target.
REQ-034 SHALL, without SLEW_LIMIT_EN defined, load the clamped target into actuator_out directly.

Verification (DIV=4, TIMEOUT=8)
REQ-035 SHALL cover: WALK, y=900 -> pid_err=100 with pid_req; ack with pid_u=300 -> actuator_out=300 one edge later (no slew).
REQ-036 SHALL cover: WALK, no ack for 8 REQ cycles -> fault=1, pid_req=0, actuator_out=0; a later STOP sample -> fault=0.
REQ-037 SHALL cover: WALK, y=65535 -> pid_err=-32768; ack with pid_u=-50 -> actuator_out=0.
REQ-038 SHALL cover: WALK->TURN change -> one-cycle pid_clr in SAMPLE; y=990 -> pid_err=-490.
REQ-039 SHALL cover: SLEW_LIMIT_EN defined, actuator_out=0, pid_u=1000 repeatedly -> actuator_out 64, then 128.
REQ-040 SHALL cover: rst low while pid_req=1 -> pid_req=0 and actuator_out=0 without a clock edge.
